// File: rtl/can_bit_timing_if.sv
// ---------------------------------------------------------------------------
// can_bit_timing_if
//   Bundles the configuration, RX input and timing strobes of can_bit_timing.
//
//   master : drives enable, brp, tseg1, tseg2, sjw, hard_sync_en and rx_in, and
//            observes the timing outputs (bit stream processor / testbench).
//   slave  : the bit timing block itself.
//
//   Signalling: there is no valid/ready handshake here. Configuration inputs
//   are quasi-static levels that are sampled when a new bit starts. tq_tick,
//   bit_start and sample_point are single-clk strobes that the consumer must
//   act on in the cycle they are high; sample_bit and seg are levels that
//   change on the clk edge that ends a strobe cycle.
// ---------------------------------------------------------------------------
interface can_bit_timing_if #(
    parameter int BRP_W   = 16,
    parameter int TSEG1_W = 4,
    parameter int TSEG2_W = 3,
    parameter int SJW_W   = 2
);
    logic               enable;
    logic [BRP_W-1:0]   brp;
    logic [TSEG1_W-1:0] tseg1;
    logic [TSEG2_W-1:0] tseg2;
    logic [SJW_W-1:0]   sjw;
    logic               hard_sync_en;
    logic               rx_in;

    logic               tq_tick;
    logic               bit_start;
    logic               sample_point;
    logic               sample_bit;
    logic [1:0]         seg;

    modport master (
        output enable, brp, tseg1, tseg2, sjw, hard_sync_en, rx_in,
        input  tq_tick, bit_start, sample_point, sample_bit, seg
    );

    modport slave (
        input  enable, brp, tseg1, tseg2, sjw, hard_sync_en, rx_in,
        output tq_tick, bit_start, sample_point, sample_bit, seg
    );
endinterface

// File: rtl/can_bit_timing.sv
// ---------------------------------------------------------------------------
// can_bit_timing
//   CAN bit timing logic: divides clk by brp into time quanta (tq), walks
//   each bit through SYNC, TSEG1 and TSEG2, strobes the TX drive point
//   (bit_start) and the sample point, and captures the RX bit. Recessive to
//   dominant RX edges cause a hard sync (hard_sync_en=1) or an SJW-limited
//   resync (at most one per bit, only if the previous bit was recessive).
//
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bt   - can_bit_timing_if.slave:
//            enable, brp, tseg1, tseg2, sjw, hard_sync_en, rx_in (inputs)
//            tq_tick, bit_start, sample_point, sample_bit, seg  (outputs)
//   seg doubles as the visible state of the segment FSM.
// ---------------------------------------------------------------------------
module can_bit_timing #(
    parameter int BRP_W   = 16,
    parameter int TSEG1_W = 4,
    parameter int TSEG2_W = 3,
    parameter int SJW_W   = 2
) (
    input logic             clk,
    input logic             rst,
    can_bit_timing_if.slave bt
);
    // TSEG1 length plus the largest SJW stretch fits in one extra bit.
    localparam int CNT_W = TSEG1_W + 1;
    localparam int T2_W  = TSEG2_W + 1;

    localparam logic [1:0] SEG_SYNC  = 2'd0;
    localparam logic [1:0] SEG_TSEG1 = 2'd1;
    localparam logic [1:0] SEG_TSEG2 = 2'd2;

    logic clr;
    assign clr = rst | ~bt.enable;

    // ---------------- prescaler ----------------
    logic [BRP_W-1:0] brp_eff, brp_last, brp_cnt;
    logic             tq_tick;

    assign brp_eff  = (bt.brp == '0) ? BRP_W'(1) : bt.brp;
    assign brp_last = brp_eff - BRP_W'(1);
    assign tq_tick  = bt.enable & ~rst & (brp_cnt == brp_last);

    // ">=" also forces a wrap when brp shrinks below the running count.
    always_ff @(posedge clk) begin
        if (clr)
            brp_cnt <= '0;
        else if (brp_cnt >= brp_last)
            brp_cnt <= '0;
        else
            brp_cnt <= brp_cnt + BRP_W'(1);
    end

    // ---------------- RX synchroniser and edge detect ----------------
    logic rx_meta, rx_sync, rx_last, rx_edge;

    always_ff @(posedge clk) begin
        if (clr) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_last <= 1'b1;
        end else begin
            rx_meta <= bt.rx_in;
            rx_sync <= rx_meta;
            if (tq_tick)
                rx_last <= rx_sync;
        end
    end

    // Recessive-to-dominant, judged on tq boundaries only.
    assign rx_edge = tq_tick & rx_last & ~rx_sync;

    // ---------------- segment FSM ----------------
    logic [1:0]       seg, seg_n;
    logic [CNT_W-1:0] tq_cnt, tq_cnt_n;
    logic [CNT_W-1:0] t1_len, t1_n, t1_cur;
    logic [T2_W-1:0]  t2_len, t2_n, t2_cur;
    logic             resync_done, rdone_n;
    logic             sample_bit, sbit_n;
    logic             bit_start_c, sample_point_c, restart;
    logic             hard_hit, resync_hit;
    logic [SJW_W:0]   sjw_len;
    logic [CNT_W-1:0] sjw_c, e_len, e_clip, r_left;

    assign sjw_len    = {1'b0, bt.sjw} + (SJW_W+1)'(1);
    assign sjw_c      = CNT_W'(sjw_len);
    assign e_len      = tq_cnt + CNT_W'(1);
    assign e_clip     = (e_len > sjw_c) ? sjw_c : e_len;
    assign r_left     = CNT_W'(t2_len) - tq_cnt;
    assign hard_hit   = rx_edge & bt.hard_sync_en;
    assign resync_hit = rx_edge & ~bt.hard_sync_en & ~resync_done & sample_bit;

    always_comb begin
        seg_n          = seg;
        tq_cnt_n       = tq_cnt;
        t1_n           = t1_len;
        t2_n           = t2_len;
        t1_cur         = t1_len;
        t2_cur         = t2_len;
        rdone_n        = resync_done;
        sbit_n         = sample_bit;
        bit_start_c    = 1'b0;
        sample_point_c = 1'b0;
        restart        = 1'b0;

        if (tq_tick) begin
            if (hard_hit) begin
                restart = 1'b1;
                rdone_n = 1'b1;
            end else begin
                // Resync adjusts the current segment length, then the
                // normal advance below runs against the adjusted length.
                if (resync_hit && seg == SEG_TSEG1) begin
                    t1_cur  = t1_len + e_clip;
                    t1_n    = t1_cur;
                    rdone_n = 1'b1;
                end else if (resync_hit && seg == SEG_TSEG2) begin
                    if (r_left <= sjw_c) begin
                        // Edge close enough to the bit end: this tq becomes SYNC.
                        restart = 1'b1;
                        rdone_n = 1'b0;
                    end else begin
                        t2_cur  = t2_len - T2_W'(sjw_len);
                        t2_n    = t2_cur;
                        rdone_n = 1'b1;
                    end
                end

                if (!restart) begin
                    case (seg)
                        SEG_SYNC: begin
                            restart = 1'b1;
                            rdone_n = 1'b0;
                        end
                        SEG_TSEG1: begin
                            if (tq_cnt == t1_cur - CNT_W'(1)) begin
                                sample_point_c = 1'b1;
                                sbit_n         = rx_sync;
                                seg_n          = SEG_TSEG2;
                                tq_cnt_n       = '0;
                            end else begin
                                tq_cnt_n = tq_cnt + CNT_W'(1);
                            end
                        end
                        SEG_TSEG2: begin
                            if (tq_cnt == CNT_W'(t2_cur) - CNT_W'(1)) begin
                                seg_n    = SEG_SYNC;
                                tq_cnt_n = '0;
                            end else begin
                                tq_cnt_n = tq_cnt + CNT_W'(1);
                            end
                        end
                        default: begin
                            seg_n    = SEG_SYNC;
                            tq_cnt_n = '0;
                        end
                    endcase
                end
            end

            // Leaving SYNC (real or implied): latch this bit's lengths.
            if (restart) begin
                seg_n       = SEG_TSEG1;
                tq_cnt_n    = '0;
                t1_n        = CNT_W'(bt.tseg1) + CNT_W'(1);
                t2_n        = T2_W'(bt.tseg2) + T2_W'(1);
                bit_start_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            seg         <= SEG_SYNC;
            tq_cnt      <= '0;
            t1_len      <= '0;
            t2_len      <= '0;
            resync_done <= 1'b0;
            sample_bit  <= 1'b1;
        end else begin
            seg         <= seg_n;
            tq_cnt      <= tq_cnt_n;
            t1_len      <= t1_n;
            t2_len      <= t2_n;
            resync_done <= rdone_n;
            sample_bit  <= sbit_n;
        end
    end

    assign bt.tq_tick      = tq_tick;
    assign bt.bit_start    = bit_start_c;
    assign bt.sample_point = sample_point_c;
    assign bt.sample_bit   = sample_bit;
    assign bt.seg          = seg;
endmodule

// File: tb/tb_can_bit_timing.sv
module tb_can_bit_timing;
    localparam int EV_TICK = 0;
    localparam int EV_BS   = 1;
    localparam int EV_SP   = 2;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

    can_bit_timing_if #(.BRP_W(16), .TSEG1_W(4), .TSEG2_W(3), .SJW_W(2)) bus ();

    can_bit_timing #(.BRP_W(16), .TSEG1_W(4), .TSEG2_W(3), .SJW_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bt  (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Reset with a fresh configuration; returns at the negedge where rst drops.
    task automatic start(input int b, input int t1, input int t2, input int sj);
        rst              = 1'b1;
        bus.enable       = 1'b1;
        bus.brp          = 16'(b);
        bus.tseg1        = 4'(t1);
        bus.tseg2        = 3'(t2);
        bus.sjw          = 2'(sj);
        bus.hard_sync_en = 1'b0;
        bus.rx_in        = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts negedges until the chosen strobe is seen; -1 on timeout.
    task automatic wait_evt(input int which, input int lim, output int n);
        bit hit;
        hit = 1'b0;
        n   = 0;
        for (int k = 0; k < lim && !hit; k++) begin
            @(negedge clk);
            n++;
            case (which)
                EV_TICK: hit = bus.tq_tick;
                EV_BS:   hit = bus.bit_start;
                default: hit = bus.sample_point;
            endcase
        end
        if (!hit) n = -1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst              = 1'b1;
        bus.enable       = 1'b1;
        bus.brp          = 16'd4;
        bus.tseg1        = 4'd5;
        bus.tseg2        = 3'd2;
        bus.sjw          = 2'd1;
        bus.hard_sync_en = 1'b0;
        bus.rx_in        = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.seg !== 2'd0) $display("FAIL reset_seg: got %0d expected 0", bus.seg); else passes++;
        checks++; if (bus.tq_tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", bus.tq_tick); else passes++;
        checks++; if (bus.bit_start !== 1'b0) $display("FAIL reset_bs: got %b expected 0", bus.bit_start); else passes++;
        checks++; if (bus.sample_point !== 1'b0) $display("FAIL reset_sp: got %b expected 0", bus.sample_point); else passes++;
        checks++; if (bus.sample_bit !== 1'b1) $display("FAIL reset_sbit: got %b expected 1", bus.sample_bit); else passes++;
    endtask

    task automatic test_nominal();
        int n;
        logic [1:0] seg_exp [10];
        seg_exp = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
        start(4, 5, 2, 1);
        // First tick (a SYNC tq, hence bit_start) acts on the 4th clk edge.
        wait_evt(EV_BS, 100, n);
        checks++; if (n !== 3) $display("FAIL nom_first_bs: got %0d expected 3", n); else passes++;
        wait_evt(EV_SP, 100, n);
        checks++; if (n !== 24) $display("FAIL nom_bs_to_sp: got %0d expected 24", n); else passes++;
        wait_evt(EV_BS, 100, n);
        checks++; if (n !== 16) $display("FAIL nom_sp_to_bs: got %0d expected 16", n); else passes++;
        checks++; if (bus.sample_bit !== 1'b1) $display("FAIL nom_sbit: got %b expected 1", bus.sample_bit); else passes++;
        checks++; if (bus.seg !== seg_exp[0]) $display("FAIL nom_seg0: got %0d expected %0d", bus.seg, seg_exp[0]); else passes++;
        for (int i = 1; i < 10; i++) begin
            wait_evt(EV_TICK, 20, n);
            checks++;
            if (n !== 4 || bus.seg !== seg_exp[i])
                $display("FAIL nom_seg%0d: got seg %0d after %0d clk expected seg %0d after 4 clk", i, bus.seg, n, seg_exp[i]);
            else passes++;
        end
        wait_evt(EV_BS, 100, n);
        checks++; if (n !== 4) $display("FAIL nom_bit_period_end: got %0d expected 4", n); else passes++;
    endtask

    task automatic test_brp();
        int n;
        start(0, 1, 0, 1);
        wait_evt(EV_TICK, 20, n);
        checks++; if (n !== 1) $display("FAIL brp0_tick: got %0d expected 1", n); else passes++;
        wait_evt(EV_BS, 20, n);
        wait_evt(EV_BS, 20, n);
        checks++; if (n !== 4) $display("FAIL brp0_bit: got %0d expected 4", n); else passes++;
        bus.brp = 16'd3;
        wait_evt(EV_TICK, 20, n);
        checks++; if (n !== 2) $display("FAIL brp3_first: got %0d expected 2", n); else passes++;
        wait_evt(EV_TICK, 20, n);
        checks++; if (n !== 3) $display("FAIL brp3_period: got %0d expected 3", n); else passes++;
        // Shrink brp below the running count: wrap is forced on the next clk.
        bus.brp = 16'd8;
        wait_evt(EV_TICK, 20, n);
        repeat (6) @(negedge clk);
        bus.brp = 16'd4;
        wait_evt(EV_TICK, 20, n);
        checks++; if (n !== 4) $display("FAIL brp_force_wrap: got %0d expected 4", n); else passes++;
    endtask

    task automatic test_hard_sync();
        int n;
        start(4, 5, 2, 1);
        bus.hard_sync_en = 1'b1;
        wait_evt(EV_BS, 100, n);
        wait_evt(EV_SP, 100, n);
        wait_evt(EV_TICK, 20, n);          // TSEG2 tq 0
        bus.rx_in = 1'b0;                  // seen on the TSEG2 tq 1 tick
        wait_evt(EV_BS, 100, n);
        checks++; if (n !== 4) $display("FAIL hard_bs: got %0d expected 4", n); else passes++;
        wait_evt(EV_SP, 100, n);
        checks++; if (n !== 24) $display("FAIL hard_sp: got %0d expected 24", n); else passes++;
        @(negedge clk);
        checks++; if (bus.sample_bit !== 1'b0) $display("FAIL hard_sbit: got %b expected 0", bus.sample_bit); else passes++;
        bus.hard_sync_en = 1'b0;
        bus.rx_in        = 1'b1;
    endtask

    task automatic test_resync_tseg1();
        int n;
        start(4, 5, 2, 1);
        wait_evt(EV_BS, 100, n);
        wait_evt(EV_TICK, 20, n);          // TSEG1 tq 0
        wait_evt(EV_TICK, 20, n);          // TSEG1 tq 1
        bus.rx_in = 1'b0;                  // edge on TSEG1 tq 2: +2 tq
        wait_evt(EV_TICK, 20, n);
        bus.rx_in = 1'b1;
        wait_evt(EV_TICK, 20, n);
        bus.rx_in = 1'b0;                  // second edge in the same bit
        wait_evt(EV_TICK, 20, n);
        bus.rx_in = 1'b1;
        wait_evt(EV_SP, 100, n);
        checks++; if (n !== 12) $display("FAIL rs1_sp: got %0d expected 12", n); else passes++;
        wait_evt(EV_BS, 100, n);
        checks++; if (n !== 16) $display("FAIL rs1_bit_end: got %0d expected 16", n); else passes++;
        checks++; if (bus.sample_bit !== 1'b1) $display("FAIL rs1_sbit: got %b expected 1", bus.sample_bit); else passes++;
    endtask

    task automatic test_resync_tseg2();
        int n;
        // r = 1 <= SJW: bit ends early.
        start(4, 5, 2, 1);
        wait_evt(EV_BS, 100, n);
        wait_evt(EV_SP, 100, n);
        wait_evt(EV_TICK, 20, n);
        wait_evt(EV_TICK, 20, n);
        bus.rx_in = 1'b0;
        wait_evt(EV_BS, 100, n);
        checks++; if (n !== 4) $display("FAIL rs2_short_bs: got %0d expected 4", n); else passes++;
        bus.rx_in = 1'b1;

        // tseg2=7, r = 8 > SJW: TSEG2 cut to 6 tq.
        start(4, 5, 7, 1);
        wait_evt(EV_BS, 100, n);
        wait_evt(EV_SP, 100, n);
        bus.rx_in = 1'b0;
        wait_evt(EV_TICK, 20, n);
        bus.rx_in = 1'b1;
        wait_evt(EV_BS, 100, n);
        checks++; if (n !== 24) $display("FAIL rs2_cut_bs: got %0d expected 24", n); else passes++;

        // Previous bit dominant: edge must be ignored.
        start(4, 5, 2, 1);
        wait_evt(EV_BS, 100, n);
        wait_evt(EV_TICK, 20, n);
        bus.rx_in = 1'b0;                  // edge on TSEG1 tq 1: +2 tq
        wait_evt(EV_SP, 100, n);
        checks++; if (n !== 28) $display("FAIL rs2_pre_sp: got %0d expected 28", n); else passes++;
        wait_evt(EV_BS, 100, n);
        checks++; if (n !== 16) $display("FAIL rs2_pre_bs: got %0d expected 16", n); else passes++;
        bus.rx_in = 1'b1;
        checks++; if (bus.sample_bit !== 1'b0) $display("FAIL rs2_dom_sbit: got %b expected 0", bus.sample_bit); else passes++;
        wait_evt(EV_TICK, 20, n);
        bus.rx_in = 1'b0;                  // edge with sample_bit=0
        wait_evt(EV_SP, 100, n);
        checks++; if (n !== 20) $display("FAIL rs2_ignored_sp: got %0d expected 20", n); else passes++;
        bus.rx_in = 1'b1;
        wait_evt(EV_BS, 100, n);
        wait_evt(EV_TICK, 20, n);          // leaves us in TSEG1, sample_bit=0
    endtask

    task automatic test_reset_mid();
        int n;
        checks++; if (bus.seg !== 2'd1 || bus.sample_bit !== 1'b0)
            $display("FAIL mid_pre: got seg %0d sbit %b expected seg 1 sbit 0", bus.seg, bus.sample_bit); else passes++;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.seg !== 2'd0) $display("FAIL mid_rst_seg: got %0d expected 0", bus.seg); else passes++;
        checks++; if ({bus.tq_tick, bus.bit_start, bus.sample_point} !== 3'b000)
            $display("FAIL mid_rst_pulses: got %b expected 000", {bus.tq_tick, bus.bit_start, bus.sample_point}); else passes++;
        checks++; if (bus.sample_bit !== 1'b1) $display("FAIL mid_rst_sbit: got %b expected 1", bus.sample_bit); else passes++;
        rst = 1'b0;
        wait_evt(EV_BS, 100, n);
        checks++; if (n !== 3) $display("FAIL mid_rst_first_bs: got %0d expected 3", n); else passes++;

        wait_evt(EV_TICK, 20, n);
        wait_evt(EV_TICK, 20, n);
        bus.enable = 1'b0;
        @(negedge clk);
        checks++; if (bus.seg !== 2'd0 || bus.tq_tick !== 1'b0 || bus.bit_start !== 1'b0)
            $display("FAIL mid_dis_state: got seg %0d tick %b bs %b expected 0 0 0", bus.seg, bus.tq_tick, bus.bit_start); else passes++;
        bus.enable = 1'b1;
        wait_evt(EV_BS, 100, n);
        checks++; if (n !== 3) $display("FAIL mid_dis_first_bs: got %0d expected 3", n); else passes++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        passes = 0;
        rst    = 1'b1;
        test_reset();
        test_nominal();
        test_brp();
        test_hard_sync();
        test_resync_tseg1();
        test_resync_tseg2();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/can_bit_timing.md
Name: can_bit_timing

Overview:
- Consumes the 16-bit `brp` value from the baud rate prescaler and generates CAN time-quantum ticks and bit-segment timing.
- Produces per-bit strobes for the bit stream processor: SYNC_SEG, TSEG1 (PROP+PHASE1) and TSEG2 (PHASE2), the sample point, a bit-start/TX point, and the sampled RX bit.
- Implements hard synchronisation and SJW-limited resynchronisation on recessive-to-dominant RX edges.

Parameters:
- BRP_W, 16, width of the brp input.
- TSEG1_W, 4, width of tseg1; TSEG1 length = tseg1+1 tq (1..16).
- TSEG2_W, 3, width of tseg2; TSEG2 length = tseg2+1 tq (1..8).
- SJW_W, 2, width of sjw; SJW = sjw+1 tq (1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; the reset is synchronous and active-high.
- enable  in  1  bit timing run; 0 holds the block in its reset state.
- brp  in  BRP_W  clocks per tq from the prescaler; 0 is treated as 1.
- tseg1  in  TSEG1_W  TSEG1 length minus 1.
- tseg2  in  TSEG2_W  TSEG2 length minus 1.
- sjw  in  SJW_W  SJW minus 1.
- hard_sync_en  in  1  1 = the next valid edge triggers a hard sync (bus idle / SOF); 0 = resync.
- rx_in  in  1  asynchronous CAN RX; 1 = recessive.
- tq_tick  out  1  one-clk pulse, once per tq.
- bit_start  out  1  one-clk pulse at the end of the SYNC tq; this is the TX drive point.
- sample_point  out  1  one-clk pulse at the end of TSEG1.
- sample_bit  out  1  RX value captured at the sample point.
- seg  out  2  current segment: 0 SYNC, 1 TSEG1, 2 TSEG2.

Behaviour:
- Reset and disable:
  - rst=1 or enable=0 at a clk edge clears brp_cnt, tq_cnt, resync_done and all pulse outputs.
  - seg goes to SYNC; sample_bit, rx_last and both synchroniser flops go to 1.
  - A mid-bit reset or disable abandons the bit. The first tq_tick occurs brp_eff clocks after enable is seen high.
- RX input: rx_in passes through a 2-flop synchroniser to give rx_sync.
- Prescaler:
  - brp_eff = (brp==0) ? 1 : brp.
  - brp_cnt counts 0..brp_eff-1 and then wraps.
  - tq_tick = enable & (brp_cnt == brp_eff-1).
  - A brp change takes effect at the next wrap.
  - If brp_cnt is already ≥ the new brp_eff, force the wrap on the next clock.
- Edge detection:
  - On each tq_tick, rx_last <= rx_sync.
  - edge = tq_tick & rx_last & ~rx_sync.
- Segment lengths:
  - On leaving SYNC: t1_len <= tseg1+1 and t2_len <= tseg2+1. These are 5-bit and 4-bit registers.
  - Config changes mid-bit do not affect the current bit.
  - SJW = sjw+1.
- Priority on each tq_tick, first match wins; state updates at the edge ending the tick cycle:
  1. Hard sync (edge & hard_sync_en):
     - The current tq is treated as SYNC.
     - seg<=TSEG1, tq_cnt<=0, reload t1_len/t2_len, resync_done<=1.
     - bit_start pulses.
  2. Resync (edge & ~hard_sync_en & ~resync_done & sample_bit==1):
     - In SYNC: no adjustment.
     - In TSEG1: e = tq_cnt+1; t1_len <= t1_len + min(e,SJW); resync_done<=1; then advance normally using the new t1_len.
     - In TSEG2: r = t2_len - tq_cnt.
       - If r ≤ SJW: treat the current tq as SYNC, i.e. seg<=TSEG1, tq_cnt<=0, reload lengths, bit_start pulses.
       - Else: t2_len <= t2_len - SJW, resync_done<=1, then advance normally.
  3. Normal advance:
     - SYNC -> TSEG1 with tq_cnt<=0 and bit_start; resync_done clears here.
     - TSEG1: tq_cnt++ until tq_cnt==t1_len-1, then sample_point pulses, sample_bit<=rx_sync, seg<=TSEG2, tq_cnt<=0.
     - TSEG2: at tq_cnt==t2_len-1, seg<=SYNC.
- Only one resync is allowed per bit. Hard sync ignores resync_done.
- Edges are ignored when sample_bit==0 (the previous bit was dominant).
- Output timing:
  - bit_start and sample_point are asserted in the same cycle as the qualifying tq_tick.
  - sample_bit and seg update at the following clk edge.
  - Nominal bit length = 1 + (tseg1+1) + (tseg2+1) tq.
- No arithmetic overflow: t1_len is at most 16+4=20 (5 bits), and t2_len - SJW is only computed when r > SJW.

Test Plan:
All scenarios except 2 use brp=4, tseg1=5 (6 tq), tseg2=2 (3 tq), sjw=1 (SJW=2), giving a 10 tq = 40 clk bit.
1. Nominal, rx_in=1, enable high -> tq_tick every 4 clk; bit_start every 40 clk; sample_point exactly 24 clk after each bit_start; seg sequence 0,1×6,2×3; sample_bit=1.
2. brp=0, tseg1=1, tseg2=0 -> tq_tick every clk; bit_start every 4 clk. Then change brp to 3 mid-count -> tq_tick period becomes 3 from the next wrap.
3. hard_sync_en=1, dominant edge detected at TSEG2 tq_cnt=1 -> bit_start in that tick cycle; next sample_point 24 clk later; sample_bit=0.
4. hard_sync_en=0, prior sample_bit=1, edge at TSEG1 tq_cnt=2 (e=3, clipped to 2) -> sample_point 8 clk later than nominal; bit is 12 tq. A second edge in the same bit -> no change.
5. Edge at TSEG2 tq_cnt=2 (r=1 ≤ SJW) -> bit_start on that tick; bit shortened to 9 tq. Edge at TSEG2 tq_cnt=0 with tseg2=7 (r=8) -> TSEG2 shortened to 6 tq. Edge with sample_bit=0 -> ignored.
6. Assert rst for 1 clk, or drop enable, mid-TSEG1 -> next cycle seg=0, all pulses 0, sample_bit=1; first tq_tick 4 clk after release.
